// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bundle: fetch and data requester channels, memory bus and status.
// The arbiter connects through the slave modport; the requesters and memory sit on master.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_done;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  d_done;

   logic                  halt;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  busy;
   logic                  owner;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      input  if_rdata, if_done, d_rdata, d_done,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      output if_rdata, if_done, d_rdata, d_done,
      output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one access at a time.
// Data wins ties; fetch is forced after MAX_DATA_STREAK data grants made while it waited.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned MEM_LATENCY     = 1,
   parameter int unsigned MAX_DATA_STREAK = 3
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int unsigned STK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [STK_W-1:0] streak;

   logic fetch_ok_c;
   logic grant_if_c;
   logic grant_d_c;

   // Arbitration decision, only acted on in IDLE.
   assign fetch_ok_c = bus.if_req & ~bus.halt;
   assign grant_if_c = fetch_ok_c & (~bus.d_req | (streak == STK_MAX));
   assign grant_d_c  = bus.d_req & ~grant_if_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         streak        <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= ADDR_WIDTH'(0);
         bus.mem_wdata <= DATA_WIDTH'(0);
         bus.if_rdata  <= DATA_WIDTH'(0);
         bus.d_rdata   <= DATA_WIDTH'(0);
         bus.if_done   <= 1'b0;
         bus.d_done    <= 1'b0;
         bus.busy      <= 1'b0;
         bus.owner     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // Streak only counts data grants that actually made fetch wait.
               if (!fetch_ok_c)     streak <= '0;
               else if (grant_d_c)  streak <= streak + STK_W'(1);
               else if (grant_if_c) streak <= '0;

               if (grant_if_c || grant_d_c) begin
                  state        <= ACCESS;
                  cnt          <= CNT_LOAD;
                  bus.busy     <= 1'b1;
                  bus.mem_en   <= 1'b1;
                  bus.owner    <= grant_d_c;
                  bus.mem_we   <= grant_d_c & bus.d_we;
                  bus.mem_addr <= grant_d_c ? bus.d_addr : bus.if_addr;
                  if (grant_d_c) bus.mem_wdata <= bus.d_wdata;
               end
            end

            ACCESS: begin
               if (cnt == '0) begin
                  if (!bus.mem_we) begin
                     if (bus.owner) bus.d_rdata  <= bus.mem_rdata;
                     else           bus.if_rdata <= bus.mem_rdata;
                  end
                  bus.mem_en  <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  bus.d_done  <= bus.owner;
                  bus.if_done <= ~bus.owner;
                  state       <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            DONE: begin
               bus.if_done <= 1'b0;
               bus.d_done  <= 1'b0;
               bus.busy    <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-timeline model.
module tb_mem_port_arbiter;
   localparam int unsigned AW   = 8;
   localparam int unsigned DW   = 16;
   localparam int unsigned LAT  = 3;
   localparam int unsigned MAXS = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Memory device seen by the DUT, and the model's own view of memory contents.
   logic [DW-1:0] dev_mem [256];
   logic [DW-1:0] ref_mem [256];
   assign bus.mem_rdata = dev_mem[bus.mem_addr];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   string       phase = "init";
   int          edge_no = 0;

   // Model: one access in flight, described by its grant edge and captured request.
   bit            m_act;
   int            m_g;
   bit            m_own, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd, m_ifr, m_dr;
   int            m_streak;
   bit            e_en, e_we, e_busy, e_ifd, e_dd;

   bit renew_if, renew_d, auto_rand;
   bit prev_en;
   bit own_log[$];
   int if_rise, d_rise, n_if_rise, n_d_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s/%s: got %h want %h (edge %0d)", phase, tag, obs, expv, edge_no);
      end
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      dev_mem[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic model_reset();
      m_act = 0; m_g = 0; m_own = 0; m_we = 0; m_streak = 0;
      m_addr = '0; m_wd = '0; m_ifr = '0; m_dr = '0;
      e_en = 0; e_we = 0; e_busy = 0; e_ifd = 0; e_dd = 0;
   endtask

   // Applies the rules at one rising edge using the inputs presented to that edge.
   task automatic model_edge();
      bit fetch_ok, pick_if, pick_d;
      int ph;
      if (m_act) begin
         ph = edge_no - m_g;
         if (ph == int'(LAT)) begin
            if (m_we)       ref_mem[m_addr] = m_wd;
            else if (m_own) m_dr  = ref_mem[m_addr];
            else            m_ifr = ref_mem[m_addr];
         end else if (ph == int'(LAT) + 1) begin
            m_act = 0;
         end
      end else begin
         fetch_ok = bus.if_req && !bus.halt;
         pick_d   = bus.d_req && !(fetch_ok && m_streak >= int'(MAXS));
         pick_if  = fetch_ok && !pick_d;
         if (!fetch_ok)    m_streak = 0;
         else if (pick_d)  m_streak = m_streak + 1;
         else              m_streak = 0;
         if (pick_if || pick_d) begin
            m_act  = 1;
            m_g    = edge_no;
            m_own  = pick_d;
            m_we   = pick_d && bus.d_we;
            m_addr = pick_d ? bus.d_addr : bus.if_addr;
            if (pick_d) m_wd = bus.d_wdata;
         end
      end
      ph     = edge_no - m_g;
      e_en   = m_act && ph < int'(LAT);
      e_we   = e_en && m_we;
      e_busy = m_act;
      e_ifd  = m_act && ph == int'(LAT) && !m_own;
      e_dd   = m_act && ph == int'(LAT) && m_own;
   endtask

   task automatic check_outputs();
      chk("mem_en",    32'(bus.mem_en),    32'(e_en));
      chk("mem_we",    32'(bus.mem_we),    32'(e_we));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("owner",     32'(bus.owner),     32'(m_own));
      chk("if_done",   32'(bus.if_done),   32'(e_ifd));
      chk("d_done",    32'(bus.d_done),    32'(e_dd));
      chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
      chk("if_rdata",  32'(bus.if_rdata),  32'(m_ifr));
      chk("d_rdata",   32'(bus.d_rdata),   32'(m_dr));
   endtask

   task automatic new_if();
      bus.if_req  = 1'b1;
      bus.if_addr = AW'($urandom_range(15));
   endtask

   task automatic new_d();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom_range(1));
      bus.d_addr  = AW'($urandom_range(15));
      bus.d_wdata = DW'($urandom);
   endtask

   // Requesters react to the model's done pulses; random mode also perturbs inputs.
   task automatic requester_update();
      if (e_ifd) begin
         if (renew_if || (auto_rand && $urandom_range(1) == 1)) new_if();
         else bus.if_req = 1'b0;
      end
      if (e_dd) begin
         if (renew_d || (auto_rand && $urandom_range(1) == 1)) new_d();
         else bus.d_req = 1'b0;
      end
      if (auto_rand) begin
         if (m_act && edge_no == m_g) begin
            if (m_own) begin
               bus.d_addr  = AW'($urandom);
               bus.d_wdata = DW'($urandom);
               bus.d_we    = 1'($urandom_range(1));
               if ($urandom_range(3) == 0) bus.d_req = 1'b0;
            end else begin
               bus.if_addr = AW'($urandom);
               if ($urandom_range(3) == 0) bus.if_req = 1'b0;
            end
         end
         if (!bus.if_req && $urandom_range(3) == 0) new_if();
         if (!bus.d_req && $urandom_range(2) == 0) new_d();
         if ($urandom_range(15) == 0) bus.halt = ~bus.halt;
      end
   endtask

   task automatic step();
      bit            wr;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      wr = bus.mem_en && bus.mem_we;
      wa = bus.mem_addr;
      wd = bus.mem_wdata;
      @(posedge clock);
      edge_no++;
      model_edge();
      if (wr) dev_mem[wa] = wd;
      #1;
      check_outputs();
      if (bus.mem_en && !prev_en) begin
         own_log.push_back(bus.owner);
         if (bus.owner) d_rise = edge_no;
         else begin if_rise = edge_no; n_if_rise++; end
      end
      prev_en = bus.mem_en;
      if (bus.d_done) n_d_done++;
      requester_update();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_logs();
      own_log.delete();
      if_rise = -1; d_rise = -1; n_if_rise = 0; n_d_done = 0;
   endtask

   task automatic apply_reset();
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus.halt = 1'b0;
      renew_if = 0; renew_d = 0; auto_rand = 0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clock);
      reset   = 1'b1;
      prev_en = 1'b0;
   endtask

   initial begin
      int store_hits;
      logic [31:0] v;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.halt = 1'b0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         poke(AW'(i), v[DW-1:0]);
      end
      poke(8'h10, 16'h1234);
      poke(8'h20, 16'hAAAA);

      phase = "reset";
      apply_reset();

      phase = "single_fetch";
      clear_logs();
      bus.if_addr = 8'h10; bus.if_req = 1'b1;
      step();
      chk("t1_en", 32'(bus.mem_en), 32'd1);
      chk("t1_addr", 32'(bus.mem_addr), 32'h10);
      steps(int'(LAT));
      chk("t1_done", 32'(bus.if_done), 32'd1);
      chk("t1_rdata", 32'(bus.if_rdata), 32'h1234);
      chk("t1_owner", 32'(bus.owner), 32'd0);
      steps(2);

      phase = "both";
      clear_logs();
      bus.if_addr = 8'h30; bus.if_req = 1'b1;
      bus.d_addr = 8'h20; bus.d_we = 1'b0; bus.d_req = 1'b1;
      steps(2 * (int'(LAT) + 2) + 2);
      chk("t2_d_rdata", 32'(bus.d_rdata), 32'hAAAA);
      chk("t2_gap", 32'(if_rise - d_rise), 32'(LAT + 2));
      chk("t2_d_first", 32'(own_log.size() > 0 ? own_log[0] : 1'b0), 32'd1);

      phase = "store";
      clear_logs();
      store_hits = 0;
      bus.d_addr = 8'h20; bus.d_wdata = 16'hBEEF; bus.d_we = 1'b1; bus.d_req = 1'b1;
      for (int i = 0; i < int'(LAT) + 4; i++) begin
         step();
         if (bus.mem_en && bus.mem_we && bus.mem_addr == 8'h20 && bus.mem_wdata == 16'hBEEF)
            store_hits++;
      end
      chk("t4_we_cycles", 32'(store_hits), 32'(LAT));
      chk("t4_done_cnt", 32'(n_d_done), 32'd1);
      chk("t4_rdata_kept", 32'(bus.d_rdata), 32'hAAAA);
      bus.d_we = 1'b0; bus.d_req = 1'b1;
      steps(int'(LAT) + 3);
      chk("t4_readback", 32'(bus.d_rdata), 32'hBEEF);

      phase = "halt";
      clear_logs();
      bus.halt = 1'b1; bus.if_addr = 8'h10; bus.if_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin bus.d_addr = 8'h11; bus.d_we = 1'b0; bus.d_req = 1'b1; end
         step();
         if (bus.if_done) bus.if_req = 1'b1;
      end
      chk("t5_if_blocked", 32'(n_if_rise), 32'd0);
      chk("t5_d_done", 32'(n_d_done), 32'd1);
      bus.halt = 1'b0;
      step();
      chk("t5_if_grant", 32'(bus.mem_en && !bus.owner), 32'd1);
      steps(int'(LAT) + 2);

      phase = "starve";
      apply_reset();
      clear_logs();
      renew_if = 1; renew_d = 1;
      bus.if_addr = 8'h01; bus.if_req = 1'b1;
      bus.d_addr = 8'h02; bus.d_we = 1'b0; bus.d_req = 1'b1;
      steps(8 * (int'(LAT) + 2) + 2);
      begin
         bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         chk("t3_grants", 32'(own_log.size() >= 8), 32'd1);
         for (int i = 0; i < 8 && i < own_log.size(); i++)
            chk($sformatf("t3_owner%0d", i), 32'(own_log[i]), 32'(pat[i]));
      end

      phase = "reset_mid";
      apply_reset();
      clear_logs();
      bus.if_addr = 8'h20; bus.if_req = 1'b1;
      steps(2);
      #2;
      reset = 1'b0;
      bus.if_req = 1'b0;
      #1;
      chk("t6_en", 32'(bus.mem_en), 32'd0);
      chk("t6_we", 32'(bus.mem_we), 32'd0);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      chk("t6_done", 32'(bus.if_done), 32'd0);
      @(posedge clock);
      #1;
      chk("t6_held_en", 32'(bus.mem_en), 32'd0);
      chk("t6_held_done", 32'(bus.if_done), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      prev_en = 1'b0;
      steps(int'(LAT) + 3);
      bus.if_addr = 8'h10; bus.if_req = 1'b1;
      steps(int'(LAT) + 1);
      chk("t6_fetch_done", 32'(bus.if_done), 32'd1);
      chk("t6_fetch_data", 32'(bus.if_rdata), 32'h1234);
      steps(2);

      phase = "random";
      apply_reset();
      auto_rand = 1;
      steps(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
